// File: rtl/deco_teclado_ext_if.sv
// PicoBlaze output-port write bus seen by the keyboard decoder.
interface deco_teclado_ext_if;
  logic       wrt_strobe;
  logic [7:0] port_ID;
  logic [7:0] tecla;

  modport master (
    output wrt_strobe,
    output port_ID,
    output tecla
  );

  modport slave (
    input wrt_strobe,
    input port_ID,
    input tecla
  );
endinterface

// File: rtl/deco_teclado_ext.sv
// PS/2 scan-code command decoder on the PicoBlaze port bus (E0/F0 aware).
// Define DECO_TECLADO_REPEAT_EN to let typematic arrow makes re-pulse.
module deco_teclado_ext #(
  parameter logic [7:0] PORT_ID     = 8'h0A,
  parameter int         TIMEOUT_CYC = 1000000,
  parameter int         CNT_W       = 20
) (
  input  logic clk,
  input  logic reset,
  deco_teclado_ext_if.slave bus,
  output logic write,
  output logic configurate,
  output logic off_alarma,
  output logic inicializate,
  output logic arriba,
  output logic abajo,
  output logic izquierda,
  output logic derecha,
  output logic T24_12,
  output logic clock_timer,
  output logic key_held,
  output logic err_seq
);

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } state_e;

  localparam int P_WR = 7;
  localparam int P_CF = 6;
  localparam int P_OA = 5;
  localparam int P_IN = 4;
  localparam int P_UP = 3;
  localparam int P_DN = 2;
  localparam int P_LF = 1;
  localparam int P_RT = 0;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic [8:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       cmd_q, cmd_d;
  logic             err_q, err_d;
  logic             t24_q, t24_d;
  logic             ct_q, ct_d;

  logic       acc;
  logic [7:0] b;
  logic       is_e0, is_f0;
  logic       hit_n, hit_e;
  logic       ext_fire;

  assign acc   = bus.wrt_strobe && (bus.port_ID == PORT_ID);
  assign b     = bus.tecla;
  assign is_e0 = (b == 8'hE0);
  assign is_f0 = (b == 8'hF0);
  assign hit_n = valid_q && (last_q == {1'b0, b});
  assign hit_e = valid_q && (last_q == {1'b1, b});

`ifdef DECO_TECLADO_REPEAT_EN
  logic is_arrow;
  assign is_arrow = (b == 8'h75) || (b == 8'h72) ||
                    (b == 8'h6B) || (b == 8'h74);
  assign ext_fire = !hit_e || is_arrow;
`else
  assign ext_fire = !hit_e;
`endif

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    last_d  = last_q;
    cnt_d   = (state_q == IDLE) ? '0 : cnt_q + 1'b1;
    cmd_d   = '0;
    err_d   = 1'b0;
    t24_d   = t24_q;
    ct_d    = ct_q;
    if (acc) begin
      cnt_d = '0;
      unique case (state_q)
        IDLE: begin
          if (is_e0) begin
            state_d = EXT;
          end else if (is_f0) begin
            state_d = BRK;
          end else begin
            valid_d = 1'b1;
            last_d  = {1'b0, b};
            if (!hit_n) begin
              unique case (b)
                8'h05:   cmd_d[P_CF] = 1'b1;
                8'h06:   ct_d = !ct_q;
                8'h04:   t24_d = !t24_q;
                8'h0C:   cmd_d[P_WR] = 1'b1;
                8'h03:   cmd_d[P_OA] = 1'b1;
                8'h07:   cmd_d[P_IN] = 1'b1;
                default: ;
              endcase
            end
          end
        end
        EXT: begin
          if (is_f0) begin
            state_d = EXT_BRK;
          end else if (is_e0) begin
            err_d = 1'b1;
          end else begin
            valid_d = 1'b1;
            last_d  = {1'b1, b};
            state_d = IDLE;
            if (ext_fire) begin
              unique case (b)
                8'h75:   cmd_d[P_UP] = 1'b1;
                8'h72:   cmd_d[P_DN] = 1'b1;
                8'h6B:   cmd_d[P_LF] = 1'b1;
                8'h74:   cmd_d[P_RT] = 1'b1;
                default: ;
              endcase
            end
          end
        end
        BRK: begin
          if (is_e0 || is_f0) begin
            err_d = 1'b1;
          end else begin
            if (hit_n) valid_d = 1'b0;
            state_d = IDLE;
          end
        end
        EXT_BRK: begin
          if (is_e0 || is_f0) begin
            err_d = 1'b1;
          end else begin
            if (hit_e) valid_d = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && cnt_q == CNT_LAST) begin
      // abandoned prefix: drop it but keep the held-key record
      state_d = IDLE;
      cnt_d   = '0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      last_q  <= '0;
      cnt_q   <= '0;
      cmd_q   <= '0;
      err_q   <= 1'b0;
      t24_q   <= 1'b0;
      ct_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      err_q   <= err_d;
      t24_q   <= t24_d;
      ct_q    <= ct_d;
    end
  end

  assign write        = cmd_q[P_WR];
  assign configurate  = cmd_q[P_CF];
  assign off_alarma   = cmd_q[P_OA];
  assign inicializate = cmd_q[P_IN];
  assign arriba       = cmd_q[P_UP];
  assign abajo        = cmd_q[P_DN];
  assign izquierda    = cmd_q[P_LF];
  assign derecha      = cmd_q[P_RT];
  assign T24_12       = t24_q;
  assign clock_timer  = ct_q;
  assign key_held     = valid_q;
  assign err_seq      = err_q;

endmodule

// File: tb/tb_deco_teclado_ext.sv
// Scoreboard bench for deco_teclado_ext with a short prefix timeout.
module tb_deco_teclado_ext;

  localparam logic [7:0] PID = 8'h0A;

  localparam logic [11:0] WR  = 12'h800;
  localparam logic [11:0] CF  = 12'h400;
  localparam logic [11:0] OA  = 12'h200;
  localparam logic [11:0] IN  = 12'h100;
  localparam logic [11:0] UP  = 12'h080;
  localparam logic [11:0] DN  = 12'h040;
  localparam logic [11:0] LF  = 12'h020;
  localparam logic [11:0] RT  = 12'h010;
  localparam logic [11:0] T24 = 12'h008;
  localparam logic [11:0] CT  = 12'h004;
  localparam logic [11:0] KH  = 12'h002;
  localparam logic [11:0] ER  = 12'h001;

`ifdef DECO_TECLADO_REPEAT_EN
  localparam logic [11:0] UP_REP = UP | KH;
`else
  localparam logic [11:0] UP_REP = KH;
`endif

  logic clk;
  logic reset;
  logic write, configurate, off_alarma, inicializate;
  logic arriba, abajo, izquierda, derecha;
  logic T24_12, clock_timer, key_held, err_seq;
  logic [11:0] obs;
  logic [11:0] sb[$];
  logic [11:0] e;
  int total;
  int bad;

  deco_teclado_ext_if bus ();

  deco_teclado_ext #(
    .PORT_ID    (PID),
    .TIMEOUT_CYC(16),
    .CNT_W      (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .write       (write),
    .configurate (configurate),
    .off_alarma  (off_alarma),
    .inicializate(inicializate),
    .arriba      (arriba),
    .abajo       (abajo),
    .izquierda   (izquierda),
    .derecha     (derecha),
    .T24_12      (T24_12),
    .clock_timer (clock_timer),
    .key_held    (key_held),
    .err_seq     (err_seq)
  );

  assign obs = {write, configurate, off_alarma, inicializate,
                arriba, abajo, izquierda, derecha,
                T24_12, clock_timer, key_held, err_seq};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic s, input logic [7:0] p,
                       input logic [7:0] d);
    bus.wrt_strobe = s;
    bus.port_ID    = p;
    bus.tecla      = d;
    @(posedge clk);
    #1;
    bus.wrt_strobe = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.wrt_strobe = 1'b0;
    bus.port_ID = 8'h00;
    bus.tecla = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (obs !== 12'h000) begin
      bad++;
      $display("FAIL reset got=%h exp=%h", obs, 12'h000);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_port();
    logic        st [10] = '{1, 1, 0, 1, 1, 1, 1, 1, 1, 1};
    logic [7:0]  pt [10] = '{8'h0A, 8'h0B, 8'h0A, 8'h0A, 8'h0A,
                             8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h0A};
    logic [7:0]  by [10] = '{8'h05, 8'h05, 8'h05, 8'h0C, 8'h03,
                             8'h07, 8'hF0, 8'h03, 8'hF0, 8'h07};
    logic [11:0] ex [10] = '{CF | KH, KH, KH, WR | KH, OA | KH,
                             IN | KH, KH, KH, KH, 12'h000};
    for (int i = 0; i < 10; i++) begin
      sb.push_back(ex[i]);
      drive(st[i], pt[i], by[i]);
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL port[%0d] got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_toggle();
    logic [7:0]  by [8] = '{8'h06, 8'h06, 8'h06, 8'hF0,
                            8'h06, 8'h06, 8'hF0, 8'h06};
    logic [11:0] ex [8] = '{CT | KH, CT | KH, CT | KH, CT | KH,
                            CT, KH, KH, 12'h000};
    for (int i = 0; i < 8; i++) begin
      sb.push_back(ex[i]);
      drive(1'b1, PID, by[i]);
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL toggle[%0d] got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_arrow();
    logic [7:0]  by [16] = '{8'hE0, 8'h75, 8'hE0, 8'h75, 8'hE0, 8'hF0,
                             8'h75, 8'hE0, 8'h72, 8'hE0, 8'h6B, 8'hE0,
                             8'h74, 8'hE0, 8'hF0, 8'h74};
    logic [11:0] ex [16] = '{12'h000, UP | KH, KH, UP_REP, KH, KH,
                             12'h000, 12'h000, DN | KH, KH, LF | KH, KH,
                             RT | KH, KH, KH, 12'h000};
    for (int i = 0; i < 16; i++) begin
      sb.push_back(ex[i]);
      drive(1'b1, PID, by[i]);
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL arrow[%0d] got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_err();
    logic [7:0]  by [8] = '{8'hF0, 8'hF0, 8'h12, 8'hE0,
                            8'hE0, 8'hF0, 8'hE0, 8'h75};
    logic [11:0] ex [8] = '{12'h000, ER, 12'h000, 12'h000,
                            ER, 12'h000, ER, 12'h000};
    for (int i = 0; i < 8; i++) begin
      sb.push_back(ex[i]);
      drive(1'b1, PID, by[i]);
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL err[%0d] got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_timeout();
    logic [7:0]  a_by [2] = '{8'h05, 8'hE0};
    logic [11:0] a_ex [2] = '{CF | KH, KH};
    logic [7:0]  b_by [3] = '{8'h75, 8'hF0, 8'h75};
    logic [11:0] b_ex [3] = '{KH, KH, 12'h000};
    logic [7:0]  c_by [3] = '{8'hE0, 8'hF0, 8'h75};
    logic [11:0] c_ex [3] = '{KH, KH, 12'h000};
    int  n;
    logic seen;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(a_ex[i]);
      drive(1'b1, PID, a_by[i]);
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL tmo_pre[%0d] got=%h exp=%h", i, obs, e);
      end
    end
    sb.push_back(ER | KH);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 24) begin
      drive(1'b0, PID, 8'h00);
      n++;
      seen = err_seq;
    end
    e = sb.pop_front();
    total++;
    if (!seen || obs !== e) begin
      bad++;
      $display("FAIL tmo_pulse got=%h exp=%h", obs, e);
    end
    total++;
    if (n !== 16) begin
      bad++;
      $display("FAIL tmo_cycles got=%0d exp=%0d", n, 16);
    end
    for (int i = 0; i < 3; i++) begin
      sb.push_back(b_ex[i]);
      drive(1'b1, PID, b_by[i]);
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL tmo_post[%0d] got=%h exp=%h", i, obs, e);
      end
    end
    drive(1'b1, PID, 8'hE0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, PID, 8'h00);
      seen = seen | err_seq;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL tmo_early got=%b exp=%b", seen, 1'b0);
    end
    sb.push_back(UP | KH);
    drive(1'b1, PID, 8'h75);
    e = sb.pop_front();
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL tmo_prio got=%h exp=%h", obs, e);
    end
    for (int i = 0; i < 3; i++) begin
      sb.push_back(c_ex[i]);
      drive(1'b1, PID, c_by[i]);
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL tmo_rel[%0d] got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0]  by [3] = '{8'h06, 8'h04, 8'hE0};
    logic [11:0] ex [3] = '{CT | KH, T24 | CT | KH, T24 | CT | KH};
    for (int i = 0; i < 3; i++) begin
      sb.push_back(ex[i]);
      drive(1'b1, PID, by[i]);
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL rmid[%0d] got=%h exp=%h", i, obs, e);
      end
    end
    reset = 1'b0;
    #2;
    total++;
    if (obs !== 12'h000) begin
      bad++;
      $display("FAIL rmid_rst got=%h exp=%h", obs, 12'h000);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    sb.push_back(T24 | KH);
    drive(1'b1, PID, 8'h04);
    e = sb.pop_front();
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL rmid_04 got=%h exp=%h", obs, e);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_port();
    test_toggle();
    test_arrow();
    test_err();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/deco_teclado_ext.md
# deco_teclado_ext

Parametrised keyboard command decoder for the PicoBlaze output-port bus. It accepts PS/2 scan-code bytes written to a programmable port ID, tracks the extended (E0) and break (F0) prefixes, and suppresses typematic repeats. It then emits one-cycle command pulses and 12/24-hour and clock/timer toggle levels to the clock/alarm datapath.

## Interface
- PORT_ID, 8'h0A, port address the decoder listens on
- TIMEOUT_CYC, 1000000, cycles without an accepted write before a pending prefix is abandoned
- CNT_W, 20, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC
- clk  in  1  system clock; all logic on its rising edge
- reset  in  1  asynchronous, active-low reset
- wrt_strobe  in  1  PicoBlaze write strobe
- port_ID  in  8  PicoBlaze port address
- tecla  in  8  scan-code byte (PicoBlaze out_port)
- write, configurate, off_alarma, inicializate  out  1 each  pulses for F4, F1, F5, F12
- arriba, abajo, izquierda, derecha  out  1 each  pulses for the arrow keys
- T24_12  out  1  12/24 mode level, toggled by F3
- clock_timer  out  1  clock/timer mode level, toggled by F2
- key_held  out  1  high while a make code is recorded with no matching break
- err_seq  out  1  one-cycle pulse on a malformed sequence or a prefix timeout

## Operation
- Accepted write: wrt_strobe==1 && port_ID==PORT_ID in the same cycle. All other cycles are ignored.
- Non-extended table: F1=05, F2=06, F3=04, F4=0C, F5=03, F12=07.
- Extended table (after E0): up=75, down=72, left=6B, right=74.
- States:
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - Any other byte is a normal make code: decode it against the non-extended table, set last_make={0,byte} and valid=1, and stay in IDLE.
  - EXT:
    - F0 -> EXT_BRK.
    - E0 -> stay in EXT and pulse err_seq.
    - Any other byte is an extended make: decode it against the extended table, set last_make={1,byte} and valid=1, then go to IDLE.
  - BRK:
    - F0 or E0 -> pulse err_seq and stay in BRK.
    - Any other byte: if valid && last_make=={0,byte}, clear valid. Then go to IDLE.
  - EXT_BRK:
    - Any byte except E0/F0: if valid && last_make=={1,byte}, clear valid. Then go to IDLE.
    - E0 or F0: pulse err_seq and stay in EXT_BRK.
- Repeat suppression: a make fires its pulse/toggle only if !(valid && last_make=={ext,byte}). Unknown codes never fire, but they are still recorded in last_make.
- A make of a different key replaces last_make. The earlier key's later break then clears nothing.
- F2/F3 invert clock_timer/T24_12. They never pulse.
- At most one command output is active in any cycle.
- key_held = valid.

## Timing
- Reset values:
  - state=IDLE, valid=0, last_make=0, counter=0.
  - All pulse outputs 0.
  - T24_12=0, clock_timer=0, key_held=0.
- Latency:
  - Pulses and toggles are registered. They appear the cycle after the accepted write and last exactly one cycle.
  - key_held updates on the same edge.
- Throughput: one accepted byte per cycle. Back-to-back accepted writes are each decoded.
- Timeout counter:
  - Cleared in IDLE and on every accepted write.
  - Increments each cycle while in EXT, BRK or EXT_BRK.
  - On reaching TIMEOUT_CYC-1, the next edge forces IDLE, pulses err_seq, and leaves valid unchanged.
- An accepted write on the same cycle the timeout expires takes priority: the byte is decoded and no timeout occurs.
- Reset mid-sequence discards the prefix and valid, and clears both toggle levels.

## Configuration
- DECO_TECLADO_REPEAT_EN defined:
  - Extended arrow makes bypass repeat suppression, so every typematic arrow make pulses.
  - Function keys remain suppressed.
- Undefined: all keys are suppressed until their break code or until a different make is received.

## Test plan
- Release reset; write 05 to port 0A -> configurate=1 for one cycle, one cycle after the write; key_held=1. Write 05 with port_ID=0B -> no response.
- Write 06 three times, then F0 06, then 06 -> clock_timer goes 0->1 once; after the break, the fourth 06 toggles it 1->0; key_held=0 after the break.
- Write E0 75, E0 75, E0 F0 75 -> arriba pulses once without the macro, and twice with DECO_TECLADO_REPEAT_EN; key_held=0 at the end.
- TIMEOUT_CYC=16: write E0, then idle 16 cycles -> err_seq pulses and the state returns to IDLE. A following 75 is then treated as a non-extended make and produces no arriba.
- Write F0 F0 -> err_seq pulses on the second byte. Then assert reset mid-sequence -> all outputs are 0 and the next 04 toggles T24_12 to 1.
